// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the 5-stage pipeline.
//   Produces stall/flush controls for the F, D and E pipeline registers,
//   forwarding selects for the E-stage ALU operands, and sequences the
//   multi-cycle multiply/divide unit while holding the pipeline.
// Configuration macro: HAZARD_FWD_EN
//   defined   -> M/W results are forwarded into E
//   undefined -> no forwarding; any RAW on an E/M destination stalls D
// Ports:
//   clk, rst_p        clock (posedge), asynchronous active-high reset
//   Ra1D/Ra2D         D-stage source addresses
//   Ra1E/Ra2E         E-stage source addresses
//   WA3E/WA3M/WA3W    destination addresses in E, M, W
//   RegWriteE/M/W     register write enables in E, M, W
//   MemtoRegE         E-stage instruction is a load
//   PCSrcE            taken branch / PC write in E
//   M_StartE          E-stage instruction is a multi-cycle op
//   MCycleDone        multi-cycle unit result valid pulse
//   StallF/D/E        hold PC, F->D, D->E registers
//   FlushD/E          clear F->D, D->E registers
//   ForwardAE/BE      operand select: 00 regfile, 01 W result, 10 M result
//   MStart            start pulse to the multi-cycle unit
//   mc_busy           multi-cycle sequencer not idle
//   stall_cnt         saturating count of cycles with StallD asserted
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W  = 16,
  parameter logic [3:0]  PC_REG = 4'd15
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic [3:0]       Ra1D,
  input  logic [3:0]       Ra2D,
  input  logic [3:0]       Ra1E,
  input  logic [3:0]       Ra2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcE,
  input  logic             M_StartE,
  input  logic             MCycleDone,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MStart,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned REG_W = 4;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RUN  = 2'd1,
    MC_DONE = 2'd2
  } mcState_t;

  mcState_t state;
  mcState_t nextState;
  logic     mcStall;
  logic     loadUse;
  logic     dataHazard;
  logic     branchFlush;
  logic     dataStall;

  // A destination hits a source unless the source is the PC (never hazards).
  function automatic logic srcMatch(input logic [REG_W-1:0] dst,
                                    input logic [REG_W-1:0] src);
    return (dst == src) && (src != PC_REG);
  endfunction

  // Multi-cycle sequencer state register.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) state <= MC_IDLE;
    else       state <= nextState;
  end

  // Multi-cycle sequencer next state; M_StartE is ignored in MC_DONE since
  // the same instruction is still leaving E.
  always_comb begin
    nextState = state;
    case (state)
      MC_IDLE: if (M_StartE)   nextState = MC_RUN;
      MC_RUN:  if (MCycleDone) nextState = MC_DONE;
      MC_DONE: nextState = MC_IDLE;
      default: nextState = MC_IDLE;
    endcase
  end

  // Multi-cycle sequencer outputs; MC_DONE releases the pipeline for one cycle.
  always_comb begin
    mcStall = 1'b0;
    MStart  = 1'b0;
    mc_busy = 1'b0;
    case (state)
      MC_IDLE: begin
        mcStall = M_StartE;
        MStart  = M_StartE & ~rst_p;
      end
      MC_RUN: begin
        mcStall = 1'b1;
        mc_busy = 1'b1;
      end
      MC_DONE: mc_busy = 1'b1;
      default: ;
    endcase
  end

  assign loadUse = MemtoRegE & RegWriteE &
                   (srcMatch(WA3E, Ra1D) | srcMatch(WA3E, Ra2D));

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src);
    if (RegWriteM && srcMatch(WA3M, src)) return 2'b10;
    if (RegWriteW && srcMatch(WA3W, src)) return 2'b01;
    return 2'b00;
  endfunction

  assign dataHazard = loadUse;
  assign ForwardAE  = fwdSel(Ra1E);
  assign ForwardBE  = fwdSel(Ra2E);
`else
  logic rawE;
  logic rawM;
  logic unusedFwdIn;

  // Without forwarding every in-flight E/M writer of a D source must drain.
  assign rawE        = RegWriteE & (srcMatch(WA3E, Ra1D) | srcMatch(WA3E, Ra2D));
  assign rawM        = RegWriteM & (srcMatch(WA3M, Ra1D) | srcMatch(WA3M, Ra2D));
  assign dataHazard  = loadUse | rawE | rawM;
  assign ForwardAE   = 2'b00;
  assign ForwardBE   = 2'b00;
  assign unusedFwdIn = ^{Ra1E, Ra2E, WA3W, RegWriteW};
`endif

  // Priority: multi-cycle stall > branch flush > data hazard bubble.
  always_comb begin
    branchFlush = PCSrcE & ~mcStall;
    dataStall   = dataHazard & ~mcStall & ~branchFlush;
    StallF      = mcStall | dataStall;
    StallD      = mcStall | dataStall;
    StallE      = mcStall;
    FlushD      = branchFlush;
    FlushE      = branchFlush | dataStall;
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p)
      stall_cnt <= '0;
    else if (StallD && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives Stall/flush ("refresh") for the F, D and E pipeline registers, and the forwarding selects for the E-stage ALU operands. It also runs a small FSM that launches and waits on the multi-cycle multiply/divide unit while holding the pipeline. It sits beside the D→E and E→M pipeline registers and consumes only register addresses and control bits from them.

Parameters:
CNT_W, 16, width of saturating stall-cycle performance counter
PC_REG, 4'd15, register index excluded from hazard matching (PC reads never hazard)

Ports:
clk  in  1  clock; all state updates on posedge
rst_p  in  1  reset, asynchronous, active-high
Ra1D  in  4  D-stage source register 1 address
Ra2D  in  4  D-stage source register 2 address
Ra1E  in  4  E-stage source register 1 address
Ra2E  in  4  E-stage source register 2 address
WA3E  in  4  E-stage destination address
WA3M  in  4  M-stage destination address
WA3W  in  4  W-stage destination address
RegWriteE  in  1  E-stage register write (condition-qualified)
RegWriteM  in  1  M-stage register write
RegWriteW  in  1  W-stage register write
MemtoRegE  in  1  E-stage instruction is a load
PCSrcE  in  1  branch/PC write taken in E (condition-qualified)
M_StartE  in  1  E-stage instruction is a multi-cycle op (condition-qualified)
MCycleDone  in  1  multi-cycle unit result valid, 1-cycle pulse
StallF  out  1  hold PC
StallD  out  1  hold F→D register
StallE  out  1  hold D→E register (its Stall input)
FlushD  out  1  clear F→D register
FlushE  out  1  clear D→E register (its refresh input)
ForwardAE  out  2  operand A select: 00 regfile, 01 W result, 10 M ALU result
ForwardBE  out  2  operand B select, same encoding
MStart  out  1  1-cycle start pulse to multi-cycle unit
mc_busy  out  1  FSM not in MC_IDLE
stall_cnt  out  CNT_W  cycles with StallD=1, saturating

Behaviour:
- Reset: FSM→MC_IDLE; stall_cnt=0; MStart=0. Stall/flush/forward outputs are combinational and evaluate to 0 under reset-time idle inputs. Reset mid-operation abandons the multi-cycle op; no MStart is re-issued until M_StartE is seen again in MC_IDLE.
- FSM states: MC_IDLE, MC_RUN, MC_DONE.
  - MC_IDLE: if M_StartE=1, assert MStart for one cycle and go to MC_RUN.
  - MC_RUN: wait for MCycleDone=1, then go to MC_DONE.
  - MC_DONE: stay one cycle, then go to MC_IDLE. M_StartE is ignored here because the same instruction is still leaving E.
- MC stall: StallF=StallD=StallE=1 when (MC_IDLE & M_StartE) or MC_RUN. In MC_DONE all three stalls are released for exactly one cycle so the op advances.
  - Latency: MStart at cycle N. If MCycleDone arrives at cycle N+k, E advances at the edge ending cycle N+k+1.
- Branch flush: PCSrcE=1 and no MC stall → FlushD=1 and FlushE=1 for that cycle.
- Load-use: MemtoRegE & RegWriteE & WA3E≠PC_REG & (WA3E==Ra1D | WA3E==Ra2D) → StallF=StallD=1 and FlushE=1 (bubble).
- Priority: MC stall > branch flush > load-use. While MC stall is active, FlushE=0 and FlushD=0. A branch flush overrides load-use: no stall that cycle, flushes only.
- Forwarding: ForwardAE=10 if RegWriteM & WA3M==Ra1E & WA3M≠PC_REG. Otherwise 01 if the same test passes with W-stage signals. Otherwise 00. M has priority over W. ForwardBE uses the same rules with Ra2E.
- The register file writes in the first half-cycle, so D-stage reads never hazard against W.
- stall_cnt: increments on each posedge with StallD=1 and holds at all-ones.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined: forwarding as described above.
- Undefined: ForwardAE=ForwardBE=00 always. An extra RAW stall applies: StallF=StallD=1 and FlushE=1 when Ra1D or Ra2D (≠PC_REG) matches WA3E with RegWriteE, or WA3M with RegWriteM. This stall has the same priority level as load-use.

Test Plan:
- Forward from M: RegWriteM=1, WA3M=3, Ra1E=3, RegWriteW=1, WA3W=3 → ForwardAE=10, ForwardBE=00 with Ra2E=4.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, Ra2D=5 → StallF=StallD=FlushE=1 for one cycle, stall_cnt 0→1.
- Branch: PCSrcE=1, no MC op → FlushD=FlushE=1, all stalls 0. Branch plus a simultaneous load-use match → flushes only.
- Multi-cycle: M_StartE=1 at cycle 0 → MStart=1 at cycle 0 only; stalls 1 through cycle 0 up to the MCycleDone cycle (done at cycle 5); cycle 6 in MC_DONE with stalls 0; cycle 7 in MC_IDLE.
- Reset mid-op: assert rst_p during MC_RUN → mc_busy=0 immediately, stall_cnt=0, no stalls after release with M_StartE=0.
- Saturation (CNT_W=4): hold a load-use stall for 20 cycles → stall_cnt stops at 15.
